mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// Byte-wide memory controller arbitrating ICache word fetches and load/store-buffer transfers.
// Optional build macro MEMCTRL_IO_STALL_EN holds stores to the IO region while io_buffer_full is high.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ic_enable,
  input  logic [31:0] ic_addr,
  output logic [31:0] ic_data,
  output logic        ic_done,
  input  logic        jump_wrong,
  input  logic        ls_enable,
  input  logic        ls_wr,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_len,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_done,
`ifdef MEMCTRL_IO_STALL_EN
  input  logic        io_buffer_full,
`endif
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic        rdy_q;
  logic [7:0]  din_q;
  logic [31:0] ic_data_d, ls_rdata_d, mem_a_d;
  logic [7:0]  mem_dout_d, rx_byte;
  logic        ic_done_d, ls_done_d, mem_wr_d, io_block;
  logic [2:0]  j;
  logic [1:0]  rx_idx;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      2'b00:   len_bytes = 3'd1;
      2'b01:   len_bytes = 3'd2;
      default: len_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    byte_sel = w[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    put_byte = w;
    put_byte[{idx, 3'b000} +: 8] = b;
  endfunction

`ifdef MEMCTRL_IO_STALL_EN
  assign io_block = ls_wr && (ls_addr[17:16] == 2'b11) && io_buffer_full;
`else
  assign io_block = 1'b0;
`endif

  // After a stall the RAM output has already moved on; din_q keeps the byte that was in flight.
  assign rx_byte = rdy_q ? mem_din : din_q;
  assign j       = cnt_q + 3'd1;
  assign rx_idx  = cnt_q[1:0] - 2'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    ic_data_d  = ic_data;
    ls_rdata_d = ls_rdata;
    ic_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    mem_a_d    = mem_a;
    mem_dout_d = mem_dout;
    mem_wr_d   = 1'b0;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (!ic_done && !ls_done) begin
            if (ls_enable && !io_block) begin
              state_d = ls_wr ? STORE : LOAD;
              cnt_d   = '0;
              n_d     = len_bytes(ls_len);
              addr_d  = ls_addr;
              wdata_d = ls_wdata;
              buf_d   = '0;
              mem_a_d = ls_addr;
              if (ls_wr) begin
                mem_wr_d   = 1'b1;
                mem_dout_d = ls_wdata[7:0];
              end
            end else if (ic_enable && !jump_wrong) begin
              state_d = IFETCH;
              cnt_d   = '0;
              n_d     = 3'd4;
              addr_d  = ic_addr;
              buf_d   = '0;
              mem_a_d = ic_addr;
            end
          end
        end
        IFETCH, LOAD: begin
          if (state_q == IFETCH && jump_wrong) begin
            state_d = IDLE;
            cnt_d   = '0;
            mem_a_d = '0;
          end else begin
            cnt_d = j;
            if (j < n_q) mem_a_d = addr_q + {29'd0, j};
            if (j >= 3'd2) buf_d = put_byte(buf_q, rx_idx, rx_byte);
            if (j == n_q + 3'd1) begin
              state_d = IDLE;
              cnt_d   = '0;
              mem_a_d = '0;
              if (state_q == IFETCH) begin
                ic_data_d = buf_d;
                ic_done_d = 1'b1;
              end else begin
                ls_rdata_d = buf_d;
                ls_done_d  = 1'b1;
              end
            end
          end
        end
        STORE: begin
          cnt_d = j;
          if (j < n_q) begin
            mem_a_d    = addr_q + {29'd0, j};
            mem_wr_d   = 1'b1;
            mem_dout_d = byte_sel(wdata_q, j[1:0]);
          end else begin
            state_d    = IDLE;
            cnt_d      = '0;
            mem_a_d    = '0;
            mem_dout_d = '0;
            ls_done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
      ic_data  <= '0;
      ic_done  <= 1'b0;
      ls_rdata <= '0;
      ls_done  <= 1'b0;
      mem_a    <= '0;
      mem_dout <= '0;
      mem_wr   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy;
      ic_data  <= ic_data_d;
      ic_done  <= ic_done_d;
      ls_rdata <= ls_rdata_d;
      ls_done  <= ls_done_d;
      mem_a    <= mem_a_d;
      mem_dout <= mem_dout_d;
      mem_wr   <= mem_wr_d;
    end
  end

  always_ff @(posedge clk) begin
    n_q     <= n_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    buf_q   <= buf_d;
    if (rdy_q) din_q <= mem_din;
  end

endmodule
